ucode_dispatch_ctrl: RTL and testbench

Issue-side controller for the multiply microcode sequencer, sitting between fetch and the decode register. It captures a decoded MUL (MULI/MULR/MULSI/MULSR) and its operands, and stalls fetch. It launches the sequencer, then steers the sequencer's generated instructions into decode until release, drains, restores flags and hands the stream back to fetch. A watchdog aborts a sequencer that never releases.

---
 rtl/ucode_pkg.sv | 26 ++
 rtl/ucode_watchdog.sv | 27 ++
 rtl/ucode_dispatch_ctrl.sv | 176 +++++++++++++++++
 tb/tb_ucode_dispatch_ctrl.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ucode_pkg.sv
// Shared definitions for the multiply microcode dispatch path: NOP encoding, MUL variants,
// dispatch FSM states and opcodes common to the sequencer.
package ucode_pkg;

    localparam logic [4:0]  OPC_NOP  = 5'b11001;
    localparam logic [4:0]  OPC_ADD  = 5'b00000;
    localparam logic [4:0]  OPC_SUB  = 5'b00001;
    localparam logic [4:0]  OPC_SHL  = 5'b00110;
    localparam logic [4:0]  OPC_SHR  = 5'b00111;
    localparam logic [4:0]  OPC_MOV  = 5'b01000;

    localparam logic [31:0] NOP = {OPC_NOP, 27'b0};

    localparam logic [1:0]  MUL_MULI  = 2'd0;
    localparam logic [1:0]  MUL_MULR  = 2'd1;
    localparam logic [1:0]  MUL_MULSI = 2'd2;
    localparam logic [1:0]  MUL_MULSR = 2'd3;

    typedef enum logic [1:0] {
        StIdle,
        StLaunch,
        StRun,
        StDrain
    } disp_state_e;

endpackage

// File: rtl/ucode_watchdog.sv
// Saturating cycle watchdog for the microcode sequencer; expire asserts in the enabled cycle
// in which the count reaches TIMEOUT.
module ucode_watchdog #(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_cnt <= '0;
        end else if (i_enable && (r_cnt != CW'(TIMEOUT))) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign o_expire = i_enable && (r_cnt >= CW'(TIMEOUT - 1));

endmodule

// File: rtl/ucode_dispatch_ctrl.sv
// Issue-side controller that hands the decode stream to the multiply microcode sequencer and back.
// Optional statistics counters are built when UCODE_DISPATCH_STATS_EN is defined.
module ucode_dispatch_ctrl
    import ucode_pkg::*;
#(
    parameter int unsigned TIMEOUT      = 1024,
    parameter int unsigned DRAIN_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] if_instr,
    input  logic        if_valid,
    input  logic        id_mul_valid,
    input  logic [3:0]  id_dest,
    input  logic [3:0]  id_src,
    input  logic [15:0] id_imm,
    input  logic [31:0] id_rs2_data,
    input  logic [1:0]  id_mul_type,
    input  logic [3:0]  flags_in,
    input  logic [31:0] uc_instr,
    input  logic        uc_mux_ctrl,
    input  logic        uc_release,
    output logic        uc_start,
    output logic [3:0]  uc_dest,
    output logic [3:0]  uc_src,
    output logic [15:0] uc_imm,
    output logic [31:0] uc_rs2_data,
    output logic [1:0]  uc_type,
    output logic [3:0]  uc_flags,
    output logic        uc_abort,
    output logic [31:0] issue_instr,
    output logic        issue_valid,
    output logic        fetch_stall,
    output logic [3:0]  flags_restore,
    output logic        flags_restore_valid,
    output logic        busy,
    output logic [1:0]  err,
    output logic [15:0] stat_muls,
    output logic [15:0] stat_stall_cycles
);

    localparam int unsigned DCW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    disp_state_e    r_state;
    disp_state_e    w_state_next;
    logic [DCW-1:0] r_drain_cnt;
    logic           w_drain_done;
    logic           w_expire;
    logic [1:0]     r_err;

    ucode_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk      (clk),
        .rst      (rst),
        .i_clear  (r_state == StLaunch),
        .i_enable (r_state == StRun),
        .o_expire (w_expire)
    );

    always_ff @(posedge clk) begin
        if (rst || (r_state != StDrain)) begin
            r_drain_cnt <= '0;
        end else begin
            r_drain_cnt <= r_drain_cnt + DCW'(1);
        end
    end

    assign w_drain_done = (r_drain_cnt == DCW'(DRAIN_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle:   if (id_mul_valid) w_state_next = StLaunch;
            StLaunch: w_state_next = StRun;
            StRun:    if (uc_release || w_expire) w_state_next = StDrain;
            StDrain:  if (w_drain_done) w_state_next = StIdle;
            default:  w_state_next = StIdle;
        endcase
    end

    // Outputs are forced to their reset values while rst is held, even though state is registered.
    always_comb begin
        issue_instr         = NOP;
        issue_valid         = 1'b0;
        uc_start            = 1'b0;
        uc_abort            = 1'b0;
        flags_restore_valid = 1'b0;
        if (!rst) begin
            case (r_state)
                StIdle: begin
                    issue_instr = if_instr;
                    issue_valid = if_valid;
                end
                StLaunch: uc_start = 1'b1;
                StRun: begin
                    issue_instr         = uc_mux_ctrl ? uc_instr : NOP;
                    issue_valid         = uc_mux_ctrl;
                    flags_restore_valid = uc_release;
                    uc_abort            = w_expire && !uc_release;
                end
                default: ;
            endcase
        end
    end

    assign fetch_stall   = !rst && ((r_state != StIdle) || id_mul_valid);
    assign busy          = (r_state != StIdle);
    assign flags_restore = uc_flags;
    assign err           = r_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            uc_dest     <= '0;
            uc_src      <= '0;
            uc_imm      <= '0;
            uc_rs2_data <= '0;
            uc_type     <= '0;
            uc_flags    <= '0;
        end else if ((r_state == StIdle) && id_mul_valid) begin
            uc_dest     <= id_dest;
            uc_src      <= id_src;
            uc_imm      <= id_imm;
            uc_rs2_data <= id_rs2_data;
            uc_type     <= id_mul_type;
            uc_flags    <= flags_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= '0;
        end else begin
            if (uc_abort) begin
                r_err[0] <= 1'b1;
            end
            if (id_mul_valid && (r_state != StIdle)) begin
                r_err[1] <= 1'b1;
            end
        end
    end

`ifdef UCODE_DISPATCH_STATS_EN
    logic [15:0] r_stat_muls;
    logic [15:0] r_stat_stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stat_muls  <= '0;
            r_stat_stall <= '0;
        end else begin
            if ((r_state == StLaunch) && (r_stat_muls != 16'hFFFF)) begin
                r_stat_muls <= r_stat_muls + 16'd1;
            end
            if (fetch_stall && (r_stat_stall != 16'hFFFF)) begin
                r_stat_stall <= r_stat_stall + 16'd1;
            end
        end
    end

    assign stat_muls         = r_stat_muls;
    assign stat_stall_cycles = r_stat_stall;
`else
    assign stat_muls         = '0;
    assign stat_stall_cycles = '0;
`endif

endmodule

// File: tb/tb_ucode_dispatch_ctrl.sv
// Scoreboard bench for ucode_dispatch_ctrl: stimulus plans each MUL sequence and queues the
// expected issue/start/flags/abort events; a negedge monitor pops and compares them.
module tb_ucode_dispatch_ctrl;
    import ucode_pkg::*;

    localparam int unsigned TO = 16;
    localparam int unsigned DR = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] if_instr;
    logic        if_valid;
    logic        id_mul_valid;
    logic [3:0]  id_dest;
    logic [3:0]  id_src;
    logic [15:0] id_imm;
    logic [31:0] id_rs2_data;
    logic [1:0]  id_mul_type;
    logic [3:0]  flags_in;
    logic [31:0] uc_instr;
    logic        uc_mux_ctrl;
    logic        uc_release;
    logic        uc_start;
    logic [3:0]  uc_dest;
    logic [3:0]  uc_src;
    logic [15:0] uc_imm;
    logic [31:0] uc_rs2_data;
    logic [1:0]  uc_type;
    logic [3:0]  uc_flags;
    logic        uc_abort;
    logic [31:0] issue_instr;
    logic        issue_valid;
    logic        fetch_stall;
    logic [3:0]  flags_restore;
    logic        flags_restore_valid;
    logic        busy;
    logic [1:0]  err;
    logic [15:0] stat_muls;
    logic [15:0] stat_stall_cycles;

    ucode_dispatch_ctrl #(
        .TIMEOUT      (TO),
        .DRAIN_CYCLES (DR)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .if_instr            (if_instr),
        .if_valid            (if_valid),
        .id_mul_valid        (id_mul_valid),
        .id_dest             (id_dest),
        .id_src              (id_src),
        .id_imm              (id_imm),
        .id_rs2_data         (id_rs2_data),
        .id_mul_type         (id_mul_type),
        .flags_in            (flags_in),
        .uc_instr            (uc_instr),
        .uc_mux_ctrl         (uc_mux_ctrl),
        .uc_release          (uc_release),
        .uc_start            (uc_start),
        .uc_dest             (uc_dest),
        .uc_src              (uc_src),
        .uc_imm              (uc_imm),
        .uc_rs2_data         (uc_rs2_data),
        .uc_type             (uc_type),
        .uc_flags            (uc_flags),
        .uc_abort            (uc_abort),
        .issue_instr         (issue_instr),
        .issue_valid         (issue_valid),
        .fetch_stall         (fetch_stall),
        .flags_restore       (flags_restore),
        .flags_restore_valid (flags_restore_valid),
        .busy                (busy),
        .err                 (err),
        .stat_muls           (stat_muls),
        .stat_stall_cycles   (stat_stall_cycles)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [63:0] val;
    } ev_t;

    ev_t  q_issue[$];
    ev_t  q_start[$];
    ev_t  q_flags[$];
    ev_t  q_abort[$];

    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    bit   mon_en = 1'b0;
    bit   exp_stall = 1'b0;
    bit   exp_busy = 1'b0;
    logic [1:0] exp_err = 2'b00;
    logic [1:0] pend_err = 2'b00;
    int   acc_stall = 0;
    int   exp_muls = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic ev_chk(input string name, input int have, input ev_t e, input logic [63:0] act);
        if (have == 0) begin
            checks++;
            failures++;
            $display("FAIL %s cyc=%0d got=%0h required=no event", name, cyc, act);
        end else begin
            chk({name, "_cycle"}, 64'(cyc), 64'(e.cyc));
            chk(name, act, e.val);
        end
    endtask

    always @(negedge clk) begin
        ev_t e;
        int  have;
        if (mon_en) begin
            chk("fetch_stall", 64'(fetch_stall), 64'(exp_stall));
            chk("busy", 64'(busy), 64'(exp_busy));
            chk("err", 64'(err), 64'(exp_err));
            if (issue_valid) begin
                have = q_issue.size();
                if (have != 0) e = q_issue.pop_front();
                ev_chk("issue", have, e, 64'(issue_instr));
            end
            if (uc_start) begin
                have = q_start.size();
                if (have != 0) e = q_start.pop_front();
                ev_chk("start", have, e,
                       64'({uc_dest, uc_src, uc_imm, uc_rs2_data, uc_type, uc_flags}));
            end
            if (flags_restore_valid) begin
                have = q_flags.size();
                if (have != 0) e = q_flags.pop_front();
                ev_chk("flags_restore", have, e, 64'(flags_restore));
            end
            if (uc_abort) begin
                have = q_abort.size();
                if (have != 0) e = q_abort.pop_front();
                ev_chk("abort", have, e, 64'(0));
            end
        end
    end

    task automatic step();
        if (rst) acc_stall = 0;
        else if (exp_stall) acc_stall++;
        @(posedge clk);
        #1;
        exp_err  = exp_err | pend_err;
        pend_err = 2'b00;
    endtask

    // Random background inputs; only the IDLE pass-through path is expected to issue them.
    task automatic drive_bg(input bit idle);
        ev_t e;
        if_instr     = $urandom;
        if_valid     = 1'($urandom_range(0, 1));
        id_mul_valid = 1'b0;
        id_dest      = 4'($urandom);
        id_src       = 4'($urandom);
        id_imm       = 16'($urandom);
        id_rs2_data  = $urandom;
        id_mul_type  = 2'($urandom);
        flags_in     = 4'($urandom);
        uc_instr     = $urandom;
        uc_mux_ctrl  = 1'($urandom_range(0, 1));
        uc_release   = ($urandom_range(0, 3) == 0);
        exp_stall    = !idle;
        exp_busy     = !idle;
        if (idle && if_valid) begin
            e.cyc = cyc;
            e.val = 64'(if_instr);
            q_issue.push_back(e);
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            drive_bg(1'b1);
            step();
        end
    endtask

    task automatic request(input logic [3:0] dest, input logic [3:0] src, input logic [15:0] imm,
                           input logic [31:0] rs2, input logic [1:0] typ, input logic [3:0] flg);
        ev_t e;
        drive_bg(1'b1);
        id_mul_valid = 1'b1;
        id_dest      = dest;
        id_src       = src;
        id_imm       = imm;
        id_rs2_data  = rs2;
        id_mul_type  = typ;
        flags_in     = flg;
        exp_stall    = 1'b1;
        e.cyc = cyc + 1;
        e.val = 64'({dest, src, imm, rs2, typ, flg});
        q_start.push_back(e);
        exp_muls++;
        step();
        drive_bg(1'b0);
        step();
    endtask

    // rel_at = RUN cycle carrying the release (0: sequencer never releases)
    task automatic do_mul(input logic [3:0] dest, input logic [3:0] src, input logic [15:0] imm,
                          input logic [31:0] rs2, input logic [1:0] typ, input logic [3:0] flg,
                          input int rel_at, input bit steer_all, input bit overlap);
        ev_t e;
        request(dest, src, imm, rs2, typ, flg);
        for (int k = 1; k <= int'(TO); k++) begin
            drive_bg(1'b0);
            uc_release = (k == rel_at);
            if (steer_all) uc_mux_ctrl = 1'b1;
            if (overlap && k == 1) begin
                id_mul_valid = 1'b1;
                pend_err[1]  = 1'b1;
            end
            if (uc_mux_ctrl) begin
                e.cyc = cyc;
                e.val = 64'(uc_instr);
                q_issue.push_back(e);
            end
            if (uc_release) begin
                e.cyc = cyc;
                e.val = 64'(flg);
                q_flags.push_back(e);
                step();
                break;
            end
            if (k == int'(TO)) begin
                e.cyc = cyc;
                e.val = 64'(0);
                q_abort.push_back(e);
                pend_err[0] = 1'b1;
            end
            step();
        end
        for (int d = 0; d < int'(DR); d++) begin
            drive_bg(1'b0);
            step();
        end
    endtask

    task automatic check_reset_outputs();
        chk("rst_issue_instr", 64'(issue_instr), 64'(NOP));
        chk("rst_issue_valid", 64'(issue_valid), 64'(0));
        chk("rst_fetch_stall", 64'(fetch_stall), 64'(0));
        chk("rst_uc_start", 64'(uc_start), 64'(0));
        chk("rst_uc_abort", 64'(uc_abort), 64'(0));
        chk("rst_flags_restore_valid", 64'(flags_restore_valid), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_err", 64'(err), 64'(0));
        chk("rst_operands", 64'({uc_dest, uc_src, uc_imm, uc_rs2_data, uc_type, uc_flags}), 64'(0));
        chk("rst_stats", 64'({stat_muls, stat_stall_cycles}), 64'(0));
    endtask

    task automatic check_stats();
`ifdef UCODE_DISPATCH_STATS_EN
        chk("stat_muls", 64'(stat_muls), 64'(exp_muls));
        chk("stat_stall_cycles", 64'(stat_stall_cycles), 64'(acc_stall));
`else
        chk("stat_muls_off", 64'(stat_muls), 64'(0));
        chk("stat_stall_off", 64'(stat_stall_cycles), 64'(0));
`endif
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout cyc=%0d", cyc);
        $fatal(1);
    end

    initial begin
        ev_t e;
        rst = 1'b1;
        drive_bg(1'b1);
        if_valid = 1'b0;
        q_issue.delete();
        step();
        step();
        check_reset_outputs();
        rst = 1'b0;
        drive_bg(1'b1);
        mon_en = 1'b1;
        step();
        idle_cycles(3);

        // MULI d=1 s=0 imm=3, four steered instructions, release on the last one
        do_mul(4'd1, 4'd0, 16'd3, 32'h0000_0007, MUL_MULI, 4'b1010, 4, 1'b1, 1'b0);
        idle_cycles(2);
        // Sequencer never releases: watchdog abort
        do_mul(4'd2, 4'd3, 16'h0010, 32'h1234_5678, MUL_MULR, 4'b0110, 0, 1'b0, 1'b0);
        idle_cycles(2);
        // Release coincides with watchdog expiry: release wins
        do_mul(4'd5, 4'd6, 16'hBEEF, 32'hCAFE_F00D, MUL_MULSI, 4'b1111, int'(TO), 1'b0, 1'b0);
        idle_cycles(1);
        // Overlapping request during RUN
        do_mul(4'd7, 4'd8, 16'h00AA, 32'hDEAD_BEEF, MUL_MULSR, 4'b0011, 5, 1'b0, 1'b1);
        idle_cycles(2);

        // Reset in the middle of RUN
        request(4'd9, 4'd4, 16'h5555, 32'h0F0F_0F0F, MUL_MULR, 4'b1001);
        for (int k = 1; k <= 3; k++) begin
            drive_bg(1'b0);
            uc_release = 1'b0;
            if (uc_mux_ctrl) begin
                e.cyc = cyc;
                e.val = 64'(uc_instr);
                q_issue.push_back(e);
            end
            step();
        end
        drive_bg(1'b0);
        uc_release  = 1'b0;
        uc_mux_ctrl = 1'b0;
        mon_en      = 1'b0;
        rst         = 1'b1;
        step();
        check_reset_outputs();
        rst = 1'b0;
        q_issue.delete();
        q_start.delete();
        q_flags.delete();
        q_abort.delete();
        exp_err   = 2'b00;
        pend_err  = 2'b00;
        exp_muls  = 0;
        drive_bg(1'b1);
        mon_en = 1'b1;
        step();

        // Two back-to-back MULs, then statistics
        do_mul(4'd3, 4'd1, 16'd9, 32'd100, MUL_MULI, 4'b0101, 3, 1'b0, 1'b0);
        do_mul(4'd4, 4'd2, 16'd1, 32'd200, MUL_MULSR, 4'b1100, 6, 1'b1, 1'b0);
        check_stats();

        for (int t = 0; t < 40; t++) begin
            int r;
            r = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, TO));
            do_mul(4'($urandom), 4'($urandom), 16'($urandom), $urandom, 2'($urandom),
                   4'($urandom), r, ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0));
            idle_cycles(int'($urandom_range(0, 3)));
        end

        idle_cycles(3);
        check_stats();
        chk("issue_queue_empty", 64'(q_issue.size()), 64'(0));
        chk("start_queue_empty", 64'(q_start.size()), 64'(0));
        chk("flags_queue_empty", 64'(q_flags.size()), 64'(0));
        chk("abort_queue_empty", 64'(q_abort.size()), 64'(0));
        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
